// File: rtl/line_buffer_scheduler.sv
// Sequencer for the vertical scaler's ring line buffer: write addressing with back-pressure,
// source-line residency handshake to the bilinear datapath, and read-pointer advance by yStep.
module line_buffer_scheduler #(
  parameter int ADDRESS_WIDTH = 11,
  parameter int BUFFER_SIZE   = 4,
  parameter int FILL_WIDTH    = 3,
  parameter int FRAC_BITS     = 14
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     frameStart,
  input  logic [ADDRESS_WIDTH-1:0] inWidth,
  input  logic [ADDRESS_WIDTH-1:0] inHeight,
  input  logic [ADDRESS_WIDTH-1:0] outHeight,
  input  logic [FRAC_BITS+1:0]     yStep,
  input  logic                     inValid,
  output logic                     inReady,
  output logic                     writeEnable,
  output logic [ADDRESS_WIDTH-1:0] writeAddress,
  output logic                     advanceWrite,
  input  logic                     lineReq,
  output logic                     lineGrant,
  output logic                     lastSrcLine,
  output logic [FRAC_BITS-1:0]     yFrac,
  input  logic                     lineDone,
  output logic                     advanceRead1,
  output logic                     advanceRead2,
  output logic [FILL_WIDTH-1:0]    fillCount,
  output logic                     frameDone
);

  localparam logic [FILL_WIDTH-1:0] FILL_FULL = FILL_WIDTH'(BUFFER_SIZE);
  localparam logic [FILL_WIDTH-1:0] FILL_ONE  = FILL_WIDTH'(1);
  localparam logic [FILL_WIDTH-1:0] FILL_TWO  = FILL_WIDTH'(2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_GRANT,
    S_BUSY,
    S_ADV,
    S_FLUSH
  } state_t;

  state_t r_state;
  state_t w_stateNext;

  logic                     r_writeArmed;
  logic [ADDRESS_WIDTH-1:0] r_writeAddress;
  logic [ADDRESS_WIDTH:0]   r_inLine;
  logic                     r_advanceWrite;
  logic [FILL_WIDTH-1:0]    r_fillCount;
  logic [FRAC_BITS+1:0]     r_yAcc;
  logic [ADDRESS_WIDTH:0]   r_outLine;

  logic                     w_transfer;
  logic                     w_lineEnd;
  logic                     w_allIn;
  logic                     w_read1;
  logic                     w_read2;
  logic                     w_grant;
  logic                     w_last;
  logic                     w_frameDone;
  logic [FRAC_BITS+1:0]     w_sum;
  logic [1:0]               w_k;
  logic [FILL_WIDTH-1:0]    w_fillNext;

  // allIn waits out the advanceWrite cycle so it never runs ahead of fillCount
  assign w_allIn    = (r_inLine > {1'b0, inHeight}) && !r_advanceWrite;
  assign inReady    = r_writeArmed && (r_fillCount < FILL_FULL) &&
                      (r_inLine <= {1'b0, inHeight}) && !r_advanceWrite;
  assign w_transfer = inValid && inReady;
  assign w_lineEnd  = w_transfer && (r_writeAddress == inWidth);
  assign w_sum      = r_yAcc + yStep;
  assign w_k        = w_sum[FRAC_BITS+1:FRAC_BITS];
  assign w_fillNext = r_fillCount + FILL_WIDTH'(r_advanceWrite) - FILL_WIDTH'(w_read1) -
                      (w_read2 ? FILL_TWO : '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_writeArmed   <= 1'b0;
      r_writeAddress <= '0;
      r_inLine       <= '0;
      r_advanceWrite <= 1'b0;
    end else if (frameStart) begin
      r_writeArmed   <= 1'b1;
      r_writeAddress <= '0;
      r_inLine       <= '0;
      r_advanceWrite <= 1'b0;
    end else begin
      r_advanceWrite <= w_lineEnd;
      if (w_lineEnd) begin
        r_writeAddress <= '0;
        r_inLine       <= r_inLine + 1'b1;
      end else if (w_transfer) begin
        r_writeAddress <= r_writeAddress + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_fillCount <= '0;
      r_yAcc      <= '0;
      r_outLine   <= '0;
    end else begin
      r_state <= w_stateNext;
      if (frameStart) begin
        r_fillCount <= '0;
        r_yAcc      <= '0;
        r_outLine   <= '0;
      end else begin
        r_fillCount <= w_fillNext;
        if (r_state == S_ADV) begin
          r_yAcc    <= {2'b00, w_sum[FRAC_BITS-1:0]};
          r_outLine <= r_outLine + 1'b1;
        end
      end
    end
  end

  // read-side sequencing; retire pulses are clipped to the lines actually resident
  always_comb begin
    w_stateNext = r_state;
    w_read1     = 1'b0;
    w_read2     = 1'b0;
    w_grant     = 1'b0;
    w_last      = 1'b0;
    w_frameDone = 1'b0;
    case (r_state)
      S_IDLE: begin
      end
      S_WAIT: begin
        if (lineReq && ((r_fillCount >= FILL_TWO) || (w_allIn && (r_fillCount >= FILL_ONE))))
          w_stateNext = S_GRANT;
      end
      S_GRANT: begin
        w_grant     = 1'b1;
        w_last      = (r_fillCount == FILL_ONE);
        w_stateNext = S_BUSY;
      end
      S_BUSY: begin
        if (lineDone) w_stateNext = S_ADV;
      end
      S_ADV: begin
        if ((w_k >= 2'd2) && (r_fillCount >= FILL_TWO)) w_read2 = 1'b1;
        else if ((w_k != 2'd0) && (r_fillCount != '0)) w_read1 = 1'b1;
        w_stateNext = (r_outLine >= {1'b0, outHeight}) ? S_FLUSH : S_WAIT;
      end
      S_FLUSH: begin
        if (r_fillCount != '0) begin
          w_read1 = 1'b1;
        end else if (w_allIn) begin
          w_frameDone = 1'b1;
          w_stateNext = S_IDLE;
        end
      end
      default: w_stateNext = S_IDLE;
    endcase
    if (frameStart) w_stateNext = S_WAIT;
  end

  assign writeEnable  = w_transfer;
  assign writeAddress = r_writeAddress;
  assign advanceWrite = r_advanceWrite;
  assign lineGrant    = w_grant;
  assign lastSrcLine  = w_last;
  assign yFrac        = r_yAcc[FRAC_BITS-1:0];
  assign advanceRead1 = w_read1;
  assign advanceRead2 = w_read2;
  assign fillCount    = r_fillCount;
  assign frameDone    = w_frameDone;

endmodule

// File: tb/tb_line_buffer_scheduler.sv
// Randomized bench for line_buffer_scheduler; expected grants, weights and retire pulses
// come from a frame-level model of source positions n*yStep.
module tb_line_buffer_scheduler;

  localparam int AW = 11;
  localparam int BS = 4;
  localparam int FW = 3;
  localparam int FB = 14;
  localparam int ONE = 1 << FB;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          frameStart = 1'b0;
  logic [AW-1:0] inWidth = '0;
  logic [AW-1:0] inHeight = '0;
  logic [AW-1:0] outHeight = '0;
  logic [FB+1:0] yStep = '0;
  logic          inValid = 1'b0;
  logic          inReady;
  logic          writeEnable;
  logic [AW-1:0] writeAddress;
  logic          advanceWrite;
  logic          lineReq = 1'b0;
  logic          lineGrant;
  logic          lastSrcLine;
  logic [FB-1:0] yFrac;
  logic          lineDone = 1'b0;
  logic          advanceRead1;
  logic          advanceRead2;
  logic [FW-1:0] fillCount;
  logic          frameDone;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  line_buffer_scheduler #(
    .ADDRESS_WIDTH(AW), .BUFFER_SIZE(BS), .FILL_WIDTH(FW), .FRAC_BITS(FB)
  ) dut (
    .clk(clk), .rst(rst), .frameStart(frameStart),
    .inWidth(inWidth), .inHeight(inHeight), .outHeight(outHeight), .yStep(yStep),
    .inValid(inValid), .inReady(inReady), .writeEnable(writeEnable),
    .writeAddress(writeAddress), .advanceWrite(advanceWrite),
    .lineReq(lineReq), .lineGrant(lineGrant), .lastSrcLine(lastSrcLine), .yFrac(yFrac),
    .lineDone(lineDone), .advanceRead1(advanceRead1), .advanceRead2(advanceRead2),
    .fillCount(fillCount), .frameDone(frameDone)
  );

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({inReady, writeEnable, advanceWrite, lineGrant, advanceRead1, advanceRead2, frameDone} !== 7'b0) begin
      errors++; $display("[TB] FAIL reset_pulses: got %b expected 0000000",
        {inReady, writeEnable, advanceWrite, lineGrant, advanceRead1, advanceRead2, frameDone});
    end
    checks++;
    if (fillCount !== 0 || writeAddress !== 0 || yFrac !== 0) begin
      errors++; $display("[TB] FAIL reset_values: got fill=%0d addr=%0d yFrac=%0d expected 0/0/0",
        fillCount, writeAddress, yFrac);
    end
    rst = 1'b0;
    inValid = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (inReady !== 1'b0) begin
      errors++; $display("[TB] FAIL idle_not_armed: got inReady=%b expected 0", inReady);
    end
    inValid = 1'b0;
    @(posedge clk); #1;
  endtask

  // Runs a full frame and checks every grant and retire pulse against the positional model.
  task automatic run_frame(input string name, input logic [AW-1:0] w, input logic [AW-1:0] h,
                           input logic [AW-1:0] oh, input logic [FB+1:0] step,
                           input int validPct, input int doneDelay, input int reqDelay);
    int expFrac[$];
    int expLast[$];
    int expReads[$];
    int gotFrac[$];
    int gotLast[$];
    int gotReads[$];
    int total, retired, pos0, pos1, kk, pulse, reads;
    int modelFill, expAddr, transfers, awCount, doneCnt;
    bit pendingAw, done, firstReadSeen, resumeNext;

    total = int'(h) + 1;
    retired = 0;
    for (int n = 0; n <= int'(oh); n++) begin
      pos0 = n * int'(step);
      pos1 = (n + 1) * int'(step);
      expFrac.push_back(pos0 % ONE);
      expLast.push_back(((total - retired) == 1) ? 1 : 0);
      kk = pos1 / ONE - pos0 / ONE;
      pulse = (kk < total - retired) ? kk : total - retired;
      if (pulse > 0) expReads.push_back(pulse);
      retired += pulse;
    end
    while (retired < total) begin
      expReads.push_back(1);
      retired++;
    end

    inWidth = w; inHeight = h; outHeight = oh; yStep = step;
    frameStart = 1'b1; inValid = 1'b0; lineReq = 1'b0; lineDone = 1'b0;
    @(posedge clk); #1;
    frameStart = 1'b0;
    modelFill = 0; expAddr = 0; transfers = 0; awCount = 0; doneCnt = -1;
    pendingAw = 0; done = 0; firstReadSeen = 0; resumeNext = 0;

    for (int cyc = 0; cyc < 20000 && !done; cyc++) begin
      inValid = ($urandom_range(99) < validPct);
      lineReq = (cyc >= reqDelay);
      lineDone = 1'b0;
      if (doneCnt > 0) begin
        doneCnt--;
        if (doneCnt == 0) begin
          lineDone = 1'b1;
          doneCnt = -1;
        end
      end
      @(negedge clk);
      reads = (advanceRead1 ? 1 : 0) + (advanceRead2 ? 2 : 0);
      checks++;
      if (fillCount !== modelFill[FW-1:0]) begin
        errors++; $display("[TB] FAIL %s fill: cycle %0d got %0d expected %0d", name, cyc, fillCount, modelFill);
      end
      checks++;
      if (advanceWrite !== pendingAw) begin
        errors++; $display("[TB] FAIL %s advanceWrite: cycle %0d got %b expected %b", name, cyc, advanceWrite, pendingAw);
      end
      checks++;
      if ((advanceRead1 && advanceRead2) || reads > modelFill) begin
        errors++; $display("[TB] FAIL %s read_pulse: cycle %0d got r1=%b r2=%b fill=%0d expected legal pulse",
          name, cyc, advanceRead1, advanceRead2, modelFill);
      end
      checks++;
      if (advanceWrite && inReady) begin
        errors++; $display("[TB] FAIL %s ready_in_advance: cycle %0d got inReady=1 expected 0", name, cyc);
      end
      if (resumeNext) begin
        resumeNext = 0;
        checks++;
        if (inReady !== 1'b1) begin
          errors++; $display("[TB] FAIL %s resume: got inReady=%b expected 1", name, inReady);
        end
      end
      pendingAw = 0;
      if (writeEnable) begin
        checks++;
        if (writeAddress !== expAddr[AW-1:0]) begin
          errors++; $display("[TB] FAIL %s writeAddress: cycle %0d got %0d expected %0d", name, cyc, writeAddress, expAddr);
        end
        transfers++;
        if (expAddr == int'(w)) begin
          expAddr = 0;
          pendingAw = 1;
        end else begin
          expAddr++;
        end
      end
      if (lineGrant) begin
        checks++;
        if (!(modelFill >= 2 || (awCount == total && modelFill >= 1))) begin
          errors++; $display("[TB] FAIL %s grant_resident: got fill=%0d written=%0d expected two lines or last line",
            name, modelFill, awCount);
        end
        gotFrac.push_back(int'(yFrac));
        gotLast.push_back(lastSrcLine ? 1 : 0);
        doneCnt = doneDelay;
      end
      if (advanceWrite) awCount++;
      if (reads > 0) begin
        gotReads.push_back(reads);
        if (!firstReadSeen) begin
          firstReadSeen = 1;
          resumeNext = (reqDelay > 0);
        end
      end
      if (reqDelay > 0 && cyc == reqDelay - 1) begin
        checks++;
        if (fillCount !== BS || inReady !== 1'b0 || transfers != BS * (int'(w) + 1) || writeAddress !== 0) begin
          errors++; $display("[TB] FAIL %s backpressure: got fill=%0d inReady=%b transfers=%0d addr=%0d expected %0d/0/%0d/0",
            name, fillCount, inReady, transfers, writeAddress, BS, BS * (int'(w) + 1));
        end
      end
      if (reqDelay > 0 && cyc == reqDelay + 1) begin
        checks++;
        if (lineGrant !== 1'b1) begin
          errors++; $display("[TB] FAIL %s grant_latency: got lineGrant=%b expected 1", name, lineGrant);
        end
      end
      if (frameDone) done = 1;
      modelFill = modelFill + (advanceWrite ? 1 : 0) - reads;
      @(posedge clk); #1;
    end

    checks++;
    if (!done) begin
      errors++; $display("[TB] FAIL %s timeout: got no frameDone expected frameDone", name);
    end
    checks++;
    if (gotFrac.size() != expFrac.size()) begin
      errors++; $display("[TB] FAIL %s grant_count: got %0d expected %0d", name, gotFrac.size(), expFrac.size());
    end
    for (int i = 0; i < gotFrac.size() && i < expFrac.size(); i++) begin
      checks++;
      if (gotFrac[i] != expFrac[i] || gotLast[i] != expLast[i]) begin
        errors++; $display("[TB] FAIL %s grant%0d: got yFrac=%0h last=%0d expected yFrac=%0h last=%0d",
          name, i, gotFrac[i], gotLast[i], expFrac[i], expLast[i]);
      end
    end
    checks++;
    if (gotReads.size() != expReads.size()) begin
      errors++; $display("[TB] FAIL %s read_count: got %0d expected %0d", name, gotReads.size(), expReads.size());
    end
    for (int i = 0; i < gotReads.size() && i < expReads.size(); i++) begin
      checks++;
      if (gotReads[i] != expReads[i]) begin
        errors++; $display("[TB] FAIL %s read%0d: got %0d expected %0d", name, i, gotReads[i], expReads[i]);
      end
    end
    checks++;
    if (awCount != total || transfers != total * (int'(w) + 1)) begin
      errors++; $display("[TB] FAIL %s write_totals: got lines=%0d pixels=%0d expected %0d/%0d",
        name, awCount, transfers, total, total * (int'(w) + 1));
    end
    inValid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({inReady, lineGrant, advanceRead1, advanceRead2, frameDone, advanceWrite} !== 6'b0 || fillCount !== 0) begin
        errors++; $display("[TB] FAIL %s after_frame: got pulses=%b fill=%0d expected quiet, fill 0", name,
          {inReady, lineGrant, advanceRead1, advanceRead2, frameDone, advanceWrite}, fillCount);
      end
      @(posedge clk); #1;
    end
    inValid = 1'b0;
    lineReq = 1'b0;
  endtask

  task automatic test_unit_step();
    run_frame("unit_step", 11'd7, 11'd3, 11'd3, 16'h4000, 100, 2, 0);
  endtask

  task automatic test_double_step();
    run_frame("double_step", 11'd7, 11'd7, 11'd3, 16'h8000, 100, 2, 0);
  endtask

  task automatic test_half_step();
    run_frame("half_step", 11'd7, 11'd1, 11'd3, 16'h2000, 100, 2, 0);
  endtask

  task automatic test_backpressure();
    run_frame("backpressure", 11'd7, 11'd7, 11'd7, 16'h4000, 100, 3, 60);
  endtask

  task automatic test_netting();
    run_frame("netting", 11'd0, 11'd7, 11'd3, 16'h8000, 100, 1, 0);
  endtask

  task automatic test_async_reset();
    bit granted;
    bit found;
    inWidth = 11'd7; inHeight = 11'd3; outHeight = 11'd3; yStep = 16'h4000;
    frameStart = 1'b1; inValid = 1'b1; lineReq = 1'b1; lineDone = 1'b0;
    @(posedge clk); #1;
    frameStart = 1'b0;
    granted = 0;
    found = 0;
    for (int cyc = 0; cyc < 200 && !found; cyc++) begin
      @(negedge clk);
      if (lineGrant) granted = 1;
      if (granted && !lineGrant && writeAddress == 5) found = 1;
      else begin
        @(posedge clk); #1;
      end
    end
    checks++;
    if (!found) begin
      errors++; $display("[TB] FAIL async_reset_setup: got no busy cycle at address 5 expected one");
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({inReady, writeEnable, advanceWrite, lineGrant, advanceRead1, advanceRead2, frameDone} !== 7'b0 ||
        writeAddress !== 0 || fillCount !== 0 || yFrac !== 0) begin
      errors++; $display("[TB] FAIL async_reset: got pulses=%b addr=%0d fill=%0d expected all zero",
        {inReady, writeEnable, advanceWrite, lineGrant, advanceRead1, advanceRead2, frameDone}, writeAddress, fillCount);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(posedge clk); #1;
      lineDone = (cyc % 3 == 0);
      @(negedge clk);
      checks++;
      if ({inReady, writeEnable, advanceWrite, lineGrant, advanceRead1, advanceRead2, frameDone} !== 7'b0) begin
        errors++; $display("[TB] FAIL post_reset_quiet: cycle %0d got %b expected 0000000", cyc,
          {inReady, writeEnable, advanceWrite, lineGrant, advanceRead1, advanceRead2, frameDone});
      end
    end
    @(posedge clk); #1;
    inValid = 1'b0; lineReq = 1'b0; lineDone = 1'b0;
    run_frame("after_reset", 11'd3, 11'd4, 11'd5, 16'h3000, 80, 2, 0);
  endtask

  task automatic test_random();
    int total, retired, pos0, pos1, kk, pulse, maxOut;
    logic [AW-1:0] w, h, oh;
    logic [FB+1:0] step;
    for (int f = 0; f < 8; f++) begin
      w = AW'($urandom_range(0, 9));
      h = AW'($urandom_range(0, 8));
      step = 16'($urandom_range(ONE / 4, 2 * ONE));
      total = int'(h) + 1;
      retired = 0;
      maxOut = 0;
      while (maxOut < 30 && total - retired >= 1) begin
        pos0 = maxOut * int'(step);
        pos1 = (maxOut + 1) * int'(step);
        kk = pos1 / ONE - pos0 / ONE;
        pulse = (kk < total - retired) ? kk : total - retired;
        retired += pulse;
        maxOut++;
      end
      oh = AW'($urandom_range(0, maxOut - 1));
      run_frame("random", w, h, oh, step, $urandom_range(30, 100), $urandom_range(1, 5), 0);
    end
  endtask

  initial begin
    test_reset();
    test_unit_step();
    test_double_step();
    test_half_step();
    test_backpressure();
    test_netting();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
